// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: SPI mode-0 byte receiver that fills the dithering frame buffer and
// hands each complete frame to pixel_algorithm_unit. Optional MISO echo: SPI_LOADER_ECHO_EN.
module spi_pixel_loader #(
    parameter int IMAGEX           = 16,
    parameter int IMAGEY           = 16,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SPI_CLK,
    input  logic                        SPI_MOSI,
    input  logic                        SPI_CS,
    output logic                        SPI_MISO,
    output logic                        wr_en,
    output logic [IMAGE_ADDR_WIDTH-1:0] wr_addr,
    output logic [RGB_SIZE-1:0]         wr_data,
    output logic                        frame_ready,
    input  logic                        frame_ack,
    output logic                        MCU_RX_RDY,
    output logic                        overrun,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

    state_t                        state_q, state_d;
    logic                          sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                          sclk_s1_d, sclk_s2_d, sclk_s3_d;
    logic                          mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;
    logic                          cs_s1_q, cs_s2_q, cs_s1_d, cs_s2_d;
    logic [2:0]                    bit_cnt_q, bit_cnt_d;
    logic [RGB_SIZE-1:0]           shift_q, shift_d, shift_nxt;
    logic                          byte_vld_q, byte_vld_d;
    logic [RGB_SIZE-1:0]           byte_q, byte_d;
    logic [IMAGE_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                          wr_en_q, wr_en_d;
    logic [IMAGE_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [RGB_SIZE-1:0]           wr_data_q, wr_data_d;
    logic                          overrun_q, overrun_d;
    logic                          sclk_rise;
    logic                          accept;
    logic                          ack_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            cs_s1_q    <= 1'b0;
            cs_s2_q    <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_s1_q  <= sclk_s1_d;
            sclk_s2_q  <= sclk_s2_d;
            sclk_s3_q  <= sclk_s3_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            cs_s1_q    <= cs_s1_d;
            cs_s2_q    <= cs_s2_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            overrun_q  <= overrun_d;
        end
    end

    // Byte assembly: CS high discards any partial byte; the 8th edge yields a one-cycle byte_vld.
    always_comb begin
        sclk_s1_d  = SPI_CLK;
        sclk_s2_d  = sclk_s1_q;
        sclk_s3_d  = sclk_s2_q;
        mosi_s1_d  = SPI_MOSI;
        mosi_s2_d  = mosi_s1_q;
        cs_s1_d    = SPI_CS;
        cs_s2_d    = cs_s1_q;
        sclk_rise  = sclk_s2_q & ~sclk_s3_q;
        shift_nxt  = {shift_q[RGB_SIZE-2:0], mosi_s2_q};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        if (cs_s2_q) begin
            bit_cnt_d = 3'd0;
            shift_d   = '0;
        end else if (sclk_rise) begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_vld_d = 1'b1;
                byte_d     = shift_nxt;
            end
        end
    end

    always_comb begin
        wr_en_d   = byte_vld_q && accept;
        wr_addr_d = wr_en_d ? addr_q : wr_addr_q;
        wr_data_d = wr_en_d ? byte_q : wr_data_q;
        overrun_d = overrun_q || (byte_vld_q && !accept);
        addr_d    = addr_q;
        if (ack_clear) begin
            addr_d = '0;
        end else if (wr_en_d) begin
            addr_d = addr_q + IMAGE_ADDR_WIDTH'(1);
        end
    end

    // frame_ready/frame_ack: frame_ready holds until frame_ack is sampled high while FULL;
    // frame_ack outside FULL has no effect. The FSM follows the registered write strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (wr_en_q) state_d = (wr_addr_q == LAST_ADDR) ? ST_FULL : ST_RECV;
            ST_RECV: if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_d = ST_FULL;
            ST_FULL: if (frame_ack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ready = (state_q == ST_FULL);
        MCU_RX_RDY  = (state_q != ST_FULL);
        accept      = (state_q != ST_FULL);
        ack_clear   = (state_q == ST_FULL) && frame_ack;
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

`ifdef SPI_LOADER_ECHO_EN
    logic [RGB_SIZE-1:0] last_byte_q, last_byte_d;
    logic [RGB_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic                sclk_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_byte_q <= '0;
            tx_shift_q  <= '0;
        end else begin
            last_byte_q <= last_byte_d;
            tx_shift_q  <= tx_shift_d;
        end
    end

    // A falling edge at bit count 0 starts a new byte slot, so reload the latest byte there.
    always_comb begin
        sclk_fall   = ~sclk_s2_q & sclk_s3_q;
        last_byte_d = byte_vld_d ? byte_d : last_byte_q;
        tx_shift_d  = tx_shift_q;
        if (cs_s2_q) begin
            tx_shift_d = last_byte_q;
        end else if (sclk_fall) begin
            tx_shift_d = (bit_cnt_q == 3'd0) ? last_byte_q : {tx_shift_q[RGB_SIZE-2:0], 1'b0};
        end
    end

    assign SPI_MISO = ~cs_s2_q & tx_shift_q[RGB_SIZE-1];
`else
    assign SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Testbench for spi_pixel_loader: directed sequence with randomized SPI timing/data,
// checked against a frame-level model of addresses, FULL/ack behaviour and echo.
`timescale 1ns/1ps
module tb_spi_pixel_loader;
  localparam int IMAGE_SIZE = 256;
  localparam int AW = 8;
  localparam int W = 32 + AW + 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic SPI_CLK = 1'b0, SPI_MOSI = 1'b0, SPI_CS = 1'b1, frame_ack = 1'b0;
  logic SPI_MISO, wr_en, frame_ready, MCU_RX_RDY, overrun;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] dbg_state;

  spi_pixel_loader dut (
    .clk(clk), .rst(rst), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
    .SPI_MISO(SPI_MISO), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .MCU_RX_RDY(MCU_RX_RDY),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // reference model: frame fill level, FULL flag, sticky overrun, last completed byte
  int m_addr = 0;
  bit m_full = 0;
  bit m_overrun = 0;
  logic [7:0] m_prev = 8'h00;
  int unsigned rise_cyc_last = 0;
  int unsigned rise8_cyc = 0;

  // scoreboard entries: {cycle of wr_en, address, data}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic model_byte(input logic [7:0] b);
    if (!m_full) begin
      exp_q.push_back({32'(rise8_cyc + 32'd4), AW'(m_addr), b});
      m_addr++;
      if (m_addr == IMAGE_SIZE) m_full = 1;
    end else begin
      m_overrun = 1;
    end
    m_prev = b;
  endtask

  // monitor: capture writes, check strobe width and frame_ready timing around writes
  logic prev_wr_en = 1'b0;
  logic [AW-1:0] prev_wr_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        got_q.push_back({32'(cyc), wr_addr, wr_data});
        chk("wr_en_one_cycle", {63'd0, prev_wr_en}, 64'd0);
        chk("ready_low_during_wr", {63'd0, frame_ready}, 64'd0);
      end
      if (prev_wr_en)
        chk("ready_after_wr", {63'd0, frame_ready}, {63'd0, (prev_wr_addr == AW'(IMAGE_SIZE - 1))});
      prev_wr_en = wr_en;
      prev_wr_addr = wr_addr;
    end else begin
      prev_wr_en = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic spi_bit(input logic b, output logic miso);
    int h = $urandom_range(4, 3);
    @(negedge clk);
    SPI_MOSI = b;
    repeat (h - 1) @(negedge clk);
    miso = SPI_MISO;
    SPI_CLK = 1'b1;
    rise_cyc_last = cyc;
    repeat (h) @(negedge clk);
    SPI_CLK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] m;
    logic mb;
    m = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], mb);
      m[i] = mb;
    end
    rise8_cyc = rise_cyc_last;
`ifdef SPI_LOADER_ECHO_EN
    chk("miso_echo", {56'd0, m}, {56'd0, m_prev});
`else
    chk("miso_tied_low", {56'd0, m}, 64'd0);
`endif
    model_byte(b);
  endtask

  // last bit completes while frame_ack is sampled in the same cycle as byte handling
  task automatic spi_byte_with_ack(input logic [7:0] b);
    logic mb;
    for (int i = 7; i >= 1; i--) spi_bit(b[i], mb);
    @(negedge clk);
    SPI_MOSI = b[0];
    repeat (2) @(negedge clk);
    SPI_CLK = 1'b1;
    repeat (3) @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    SPI_CLK = 1'b0;
    m_overrun = 1;
    m_full = 0;
    m_addr = 0;
    m_prev = b;
  endtask

  task automatic spi_partial(input int n);
    logic mb;
    for (int i = 0; i < n; i++) spi_bit(1'($urandom_range(1, 0)), mb);
  endtask

  task automatic cs_low();
    @(negedge clk);
    SPI_CS = 1'b0;
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    SPI_CS = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    if (m_full) begin
      m_full = 0;
      m_addr = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    SPI_CLK = 1'b0;
    SPI_CS = 1'b1;
    frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {56'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", {56'd0, wr_data}, 64'd0);
    chk("rst_frame_ready", {63'd0, frame_ready}, 64'd0);
    chk("rst_mcu_rx_rdy", {63'd0, MCU_RX_RDY}, 64'd1);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    chk("rst_miso", {63'd0, SPI_MISO}, 64'd0);
    rst = 1'b1;
    m_addr = 0;
    m_full = 0;
    m_overrun = 0;
    m_prev = 8'h00;
    exp_q.delete();
    got_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // scoreboard drain
  task automatic check_writes(input string tag);
    logic [W-1:0] e, g;
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk(tag, 64'(g), 64'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_frame_ready"}, {63'd0, frame_ready}, {63'd0, m_full});
    chk({tag, "_mcu_rx_rdy"}, {63'd0, MCU_RX_RDY}, {63'd0, !m_full});
    chk({tag, "_overrun"}, {63'd0, overrun}, {63'd0, m_overrun});
    chk({tag, "_wr_en_idle"}, {63'd0, wr_en}, 64'd0);
  endtask

  initial begin
    do_reset();
    check_status("after_reset");

    cs_low();
    spi_byte(8'hA5);
    check_writes("wr_a5");
    check_status("recv_a5");

    pulse_ack();
    repeat (2) @(negedge clk);
    check_status("ack_in_recv");

    spi_partial(5);
    cs_high();
    cs_low();
    spi_byte(8'h3C);
    check_writes("wr_3c_after_partial");

    do_reset();
    check_status("mid_op_reset");

    for (int burst = 0; burst < 2; burst++) begin
      cs_low();
      for (int i = 0; i < 128; i++) spi_byte(8'(burst * 128 + i));
      cs_high();
    end
    check_writes("wr_ramp");
    check_status("ramp_full");

    cs_low();
    spi_byte(8'h77);
    check_writes("wr_none_when_full");
    check_status("overrun_77");

    pulse_ack();
    chk("ack_frame_ready", {63'd0, frame_ready}, 64'd0);
    chk("ack_mcu_rx_rdy", {63'd0, MCU_RX_RDY}, 64'd1);
    spi_byte(8'h11);
    check_writes("wr_11_addr0");

    while (!m_full) spi_byte(8'($urandom_range(255, 0)));
    check_writes("wr_random_fill");
    check_status("random_full");

    spi_byte_with_ack(8'($urandom_range(255, 0)));
    check_writes("wr_none_ack_and_byte");
    check_status("ack_and_byte");
    spi_byte(8'($urandom_range(255, 0)));
    check_writes("wr_after_ack_and_byte");
    cs_high();

    do_reset();
    cs_low();
    spi_byte(8'h5A);
    spi_byte(8'hC3);
    check_writes("wr_echo_pair");
    check_status("echo_pair");
    cs_high();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
